// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg
// Shared definitions for the memory-mapped countdown timer: register
// addresses, CTRL field positions, mode codes and the FSM state encoding.
// No ports (package).
package timer_counter_pkg;

  // Register select values (bridge word address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  // Mode field codes; any code other than MODE_RELOAD runs one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Modes 2'b10 and 2'b11 fall back to one-shot behaviour
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD) && (mode != MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// timer_counter
// Memory-mapped 32-bit countdown timer with CTRL / PRESET / COUNT registers,
// one-shot and auto-reload modes, and a maskable interrupt.
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - synchronous, active-high reset
//   addr  - register select (bridge dev_addr[3:2])
//   we    - write strobe for this device
//   wd    - 32-bit write data
//   rd    - 32-bit read data, combinational from addr
//   irq   - interrupt request, IM & int_pending
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       preset;
  logic [31:0]       count;
  logic              int_pending;
  state_t            state;

  logic ctrl_we;
  logic preset_we;

  assign ctrl_we   = we && (addr == ADDR_CTRL);
  assign preset_we = we && (addr == ADDR_PRESET);

  // Timer FSM plus register file. The CPU CTRL write is applied after the
  // FSM updates so it overrides the hardware En clear and the pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl        <= '0;
      preset      <= '0;
      count       <= '0;
      int_pending <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      if (preset_we) begin
        preset <= wd;
      end

      case (state)
        ST_IDLE: begin
          if (ctrl[CTRL_EN]) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // Covers both count == 1 and a zero preset; never wraps
            count       <= '0;
            state       <= ST_INT;
            int_pending <= 1'b1;
          end
        end
        ST_INT: begin
          if (is_reload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
            int_pending <= 1'b0;
            state       <= ST_LOAD;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (ctrl_we) begin
        ctrl        <= wd[CTRL_W-1:0];
        int_pending <= 1'b0;
      end
    end
  end

  // Read mux; unused CTRL bits and the reserved address read as zero
  always_comb begin
    rd = '0;
    case (addr)
      ADDR_CTRL:   rd = {{(32-CTRL_W){1'b0}}, ctrl};
      ADDR_PRESET: rd = preset;
      ADDR_COUNT:  rd = count;
      default:     rd = '0;
    endcase
  end

  assign irq = ctrl[CTRL_IM] & int_pending;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter
// Self-checking bench for timer_counter: a table of per-cycle vectors for the
// basic one-shot, auto-reload and zero-preset runs, followed by hand-written
// sequences for mid-count writes, pause/re-enable and interrupt masking.
// No ports.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[$];

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t rv(input string n, input logic [1:0] a,
                              input logic [31:0] e, input logic i);
    vec_t v;
    v.we = 1'b0; v.addr = a; v.wd = '0;
    v.chk_rd = 1'b1; v.exp_rd = e; v.exp_irq = i; v.name = n;
    return v;
  endfunction

  function automatic vec_t wv(input string n, input logic [1:0] a,
                              input logic [31:0] d, input logic i);
    vec_t v;
    v.we = 1'b1; v.addr = a; v.wd = d;
    v.chk_rd = 1'b0; v.exp_rd = '0; v.exp_irq = i; v.name = n;
    return v;
  endfunction

  // Advance past the next rising edge and settle
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
    we   = w;
    addr = a;
    wd   = d;
    #1;
  endtask

  task automatic check_output(input string name, input logic chk_rd,
                              input logic [31:0] exp_rd, input logic exp_irq);
    if (chk_rd) begin
      n_cmp++;
      if (rd !== exp_rd) begin
        n_err++;
        $display("[TB] FAIL %s rd: got 0x%08h expected 0x%08h", name, rd, exp_rd);
      end
    end
    n_cmp++;
    if (irq !== exp_irq) begin
      n_err++;
      $display("[TB] FAIL %s irq: got %b expected %b", name, irq, exp_irq);
    end
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a,
                        input logic [31:0] e, input logic i);
    apply_stimulus(1'b0, a, 32'd0);
    check_output(name, 1'b1, e, i);
    cycle();
  endtask

  task automatic wr(input string name, input logic [1:0] a,
                    input logic [31:0] d, input logic i);
    apply_stimulus(1'b1, a, d);
    check_output(name, 1'b0, 32'd0, i);
    cycle();
  endtask

  task automatic idle();
    apply_stimulus(1'b0, ADDR_COUNT, 32'd0);
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'b00;
    wd    = '0;

    // Reset state: all addresses read zero, no interrupt
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(rv($sformatf("rst_addr%0d", i), 2'(i), 32'd0, 1'b0));
    end

    // One-shot, PRESET=5, CTRL=0x9 written at E0
    vecs.push_back(wv("s1_preset",  ADDR_PRESET, 32'd5, 1'b0));
    vecs.push_back(wv("s1_ctrl",    ADDR_CTRL,   32'h9, 1'b0));
    vecs.push_back(rv("s1_e0",      ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s1_e1",      ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s1_e2",      ADDR_COUNT,  32'd5, 1'b0));
    vecs.push_back(rv("s1_e3",      ADDR_COUNT,  32'd4, 1'b0));
    vecs.push_back(rv("s1_e4",      ADDR_COUNT,  32'd3, 1'b0));
    vecs.push_back(rv("s1_e5",      ADDR_COUNT,  32'd2, 1'b0));
    vecs.push_back(rv("s1_e6",      ADDR_COUNT,  32'd1, 1'b0));
    vecs.push_back(rv("s1_e7",      ADDR_COUNT,  32'd0, 1'b1));
    vecs.push_back(rv("s1_en_clr",  ADDR_CTRL,   32'h8, 1'b1));
    vecs.push_back(rv("s1_hold",    ADDR_COUNT,  32'd0, 1'b1));
    vecs.push_back(wv("s1_ack",     ADDR_CTRL,   32'h8, 1'b1));
    vecs.push_back(rv("s1_acked",   ADDR_CTRL,   32'h8, 1'b0));

    // Auto-reload, PRESET=3, CTRL=0xB: 5-cycle period, 1-cycle irq pulse
    vecs.push_back(wv("s2_preset",  ADDR_PRESET, 32'd3, 1'b0));
    vecs.push_back(wv("s2_ctrl",    ADDR_CTRL,   32'hB, 1'b0));
    vecs.push_back(rv("s2_e0",      ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s2_e1",      ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s2_e2",      ADDR_COUNT,  32'd3, 1'b0));
    vecs.push_back(rv("s2_e3",      ADDR_COUNT,  32'd2, 1'b0));
    vecs.push_back(rv("s2_e4",      ADDR_COUNT,  32'd1, 1'b0));
    vecs.push_back(rv("s2_e5_int",  ADDR_COUNT,  32'd0, 1'b1));
    vecs.push_back(rv("s2_e6_load", ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s2_e7",      ADDR_COUNT,  32'd3, 1'b0));
    vecs.push_back(rv("s2_e8",      ADDR_COUNT,  32'd2, 1'b0));
    vecs.push_back(rv("s2_e9",      ADDR_COUNT,  32'd1, 1'b0));
    vecs.push_back(rv("s2_e10_int", ADDR_COUNT,  32'd0, 1'b1));
    vecs.push_back(rv("s2_e11",     ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s2_e12",     ADDR_COUNT,  32'd3, 1'b0));
    vecs.push_back(wv("s2_stop",    ADDR_CTRL,   32'h0, 1'b0));
    vecs.push_back(rv("s2_pause0",  ADDR_COUNT,  32'd1, 1'b0));
    vecs.push_back(rv("s2_pause1",  ADDR_COUNT,  32'd1, 1'b0));
    vecs.push_back(rv("s2_pause2",  ADDR_COUNT,  32'd1, 1'b0));

    // Zero preset: INT at E3 with no wrap
    vecs.push_back(wv("s3_preset",  ADDR_PRESET, 32'd0, 1'b0));
    vecs.push_back(wv("s3_ctrl",    ADDR_CTRL,   32'h9, 1'b0));
    vecs.push_back(rv("s3_e0",      ADDR_COUNT,  32'd1, 1'b0));
    vecs.push_back(rv("s3_e1",      ADDR_COUNT,  32'd1, 1'b0));
    vecs.push_back(rv("s3_e2",      ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s3_e3_int",  ADDR_COUNT,  32'd0, 1'b1));
    vecs.push_back(rv("s3_ctrl_rd", ADDR_CTRL,   32'h8, 1'b1));
    vecs.push_back(rv("s3_nowrap",  ADDR_COUNT,  32'd0, 1'b1));

    // CPU CTRL write on the same edge the hardware clears En; mode 2'b10
    vecs.push_back(wv("s4_ctrl",    ADDR_CTRL,   32'h9, 1'b1));
    vecs.push_back(rv("s4_e0",      ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s4_e1",      ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s4_e2",      ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(wv("s4_race",    ADDR_CTRL,   32'hD, 1'b1));
    vecs.push_back(rv("s4_cpu_won", ADDR_CTRL,   32'hD, 1'b0));
    vecs.push_back(rv("s4_load",    ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s4_cnt",     ADDR_COUNT,  32'd0, 1'b0));
    vecs.push_back(rv("s4_int",     ADDR_COUNT,  32'd0, 1'b1));
    vecs.push_back(rv("s4_mode2_os",ADDR_CTRL,   32'hC, 1'b1));
    vecs.push_back(wv("s4_ack",     ADDR_CTRL,   32'h0, 1'b1));
    vecs.push_back(rv("s4_acked",   ADDR_CTRL,   32'h0, 1'b0));

    repeat (3) cycle();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wd);
      check_output(vecs[i].name, vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_irq);
      cycle();
    end

    // PRESET and COUNT writes during a run
    wr("a_preset", ADDR_PRESET, 32'd10, 1'b0);
    wr("a_ctrl", ADDR_CTRL, 32'h9, 1'b0);
    rd_chk("a_e0", ADDR_COUNT, 32'd0, 1'b0);
    rd_chk("a_e1", ADDR_COUNT, 32'd0, 1'b0);
    rd_chk("a_e2", ADDR_COUNT, 32'd10, 1'b0);
    wr("a_preset100", ADDR_PRESET, 32'd100, 1'b0);
    wr("a_count_wr", ADDR_COUNT, 32'h1234, 1'b0);
    rd_chk("a_e5", ADDR_COUNT, 32'd7, 1'b0);
    for (int k = 4; k <= 9; k++) begin
      rd_chk($sformatf("a_k%0d", k), ADDR_COUNT, 32'(10 - k), 1'b0);
    end
    rd_chk("a_expire", ADDR_COUNT, 32'd0, 1'b1);
    rd_chk("a_preset_rd", ADDR_PRESET, 32'd100, 1'b1);
    wr("a_restart", ADDR_CTRL, 32'h9, 1'b1);
    rd_chk("a_r0", ADDR_COUNT, 32'd0, 1'b0);
    rd_chk("a_r1", ADDR_COUNT, 32'd0, 1'b0);
    rd_chk("a_reload100", ADDR_COUNT, 32'd100, 1'b0);
    wr("a_stop", ADDR_CTRL, 32'h0, 1'b0);
    idle();

    // Pause at COUNT=4, then re-enable reloads from PRESET
    wr("b_preset", ADDR_PRESET, 32'd8, 1'b0);
    wr("b_ctrl", ADDR_CTRL, 32'h9, 1'b0);
    idle();
    idle();
    rd_chk("b_e2", ADDR_COUNT, 32'd8, 1'b0);
    rd_chk("b_e3", ADDR_COUNT, 32'd7, 1'b0);
    rd_chk("b_e4", ADDR_COUNT, 32'd6, 1'b0);
    wr("b_pause", ADDR_CTRL, 32'h8, 1'b0);
    for (int j = 0; j < 3; j++) begin
      rd_chk($sformatf("b_hold%0d", j), ADDR_COUNT, 32'd4, 1'b0);
    end
    wr("b_resume", ADDR_CTRL, 32'h9, 1'b0);
    rd_chk("b_r0", ADDR_COUNT, 32'd4, 1'b0);
    rd_chk("b_r1", ADDR_COUNT, 32'd4, 1'b0);
    rd_chk("b_reload", ADDR_COUNT, 32'd8, 1'b0);

    // Masked run: pending sets without irq; a CTRL write then clears it
    wr("b_mask", ADDR_CTRL, 32'h1, 1'b0);
    for (int j = 5; j <= 11; j++) begin
      rd_chk($sformatf("b_m%0d", j), ADDR_COUNT, 32'(11 - j), 1'b0);
    end
    rd_chk("b_mask_done", ADDR_CTRL, 32'h0, 1'b0);
    wr("b_unmask", ADDR_CTRL, 32'h8, 1'b0);
    rd_chk("b_unmask_rd", ADDR_CTRL, 32'h8, 1'b0);
    rd_chk("b_no_irq", ADDR_COUNT, 32'd0, 1'b0);

    // Reset in the middle of an auto-reload run
    wr("c_preset", ADDR_PRESET, 32'd7, 1'b0);
    wr("c_ctrl", ADDR_CTRL, 32'hB, 1'b0);
    repeat (4) idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("c_rst_addr%0d", i), 2'(i), 32'd0, 1'b0);
    end
    rd_chk("c_stays_idle", ADDR_COUNT, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
